// File: rtl/prog_mem_arbiter.sv
// Single-port program memory arbiter: host loader versus two instruction-fetch ports.
// Host has priority, limited by a burst counter while a fetch is pending; H_LOCK blocks fetches.
module prog_mem_arbiter #(
    parameter int DW         = 18,
    parameter int AW         = 12,
    parameter int HOST_BURST = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          H_REQ,
    input  logic          H_WE,
    input  logic          H_LOCK,
    input  logic [AW-1:0] H_A,
    input  logic [DW-1:0] H_DI,
    output logic          H_GNT,
    output logic [DW-1:0] H_DQ,
    output logic          H_DV,
    input  logic          F0_REQ,
    input  logic [AW-1:0] F0_A,
    output logic          F0_GNT,
    output logic [DW-1:0] F0_DQ,
    output logic          F0_DV,
    input  logic          F1_REQ,
    input  logic [AW-1:0] F1_A,
    output logic          F1_GNT,
    output logic [DW-1:0] F1_DQ,
    output logic          F1_DV,
    output logic [AW-1:0] M_A,
    output logic          M_WE,
    output logic [DW-1:0] M_DI,
    input  logic [DW-1:0] M_DQ
);

    localparam logic [3:0] BURST_MAX = 4'(HOST_BURST);

    logic          rr_q, rr_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [DW-1:0] hdq_q, hdq_d, f0dq_q, f0dq_d, f1dq_q, f1dq_d;
    logic          hdv_q, hdv_d, f0dv_q, f0dv_d, f1dv_q, f1dv_d;
    logic          fetch_pend;
    logic          gnt_h, gnt_f0, gnt_f1;

    assign fetch_pend = F0_REQ | F1_REQ;

    // Grants are forced low while reset is asserted so no write can commit at that edge.
    always_comb begin
        gnt_h  = 1'b0;
        gnt_f0 = 1'b0;
        gnt_f1 = 1'b0;
        if (nRST) begin
            if (H_REQ && (H_LOCK || (bcnt_q < BURST_MAX) || !fetch_pend)) begin
                gnt_h = 1'b1;
            end else if (fetch_pend && !H_LOCK) begin
                if (F0_REQ && (!F1_REQ || !rr_q)) begin
                    gnt_f0 = 1'b1;
                end else begin
                    gnt_f1 = 1'b1;
                end
            end else if (H_REQ) begin
                gnt_h = 1'b1;
            end
        end
    end

    always_comb begin
        H_GNT  = gnt_h;
        F0_GNT = gnt_f0;
        F1_GNT = gnt_f1;
        M_WE   = gnt_h & H_WE;
        M_DI   = H_DI;
        if (gnt_h) begin
            M_A = H_A;
        end else if (gnt_f0) begin
            M_A = F0_A;
        end else if (gnt_f1) begin
            M_A = F1_A;
        end else begin
            M_A = '0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_f0) begin
            rr_d = 1'b1;
        end else if (gnt_f1) begin
            rr_d = 1'b0;
        end

        bcnt_d = bcnt_q;
        if (H_LOCK) begin
            bcnt_d = '0;
        end else if (gnt_h && fetch_pend) begin
            bcnt_d = (bcnt_q >= BURST_MAX) ? BURST_MAX : bcnt_q + 4'd1;
        end else if (gnt_f0 || gnt_f1 || !fetch_pend) begin
            bcnt_d = '0;
        end

        hdv_d  = gnt_h & ~H_WE;
        f0dv_d = gnt_f0;
        f1dv_d = gnt_f1;
        hdq_d  = hdv_d  ? M_DQ : hdq_q;
        f0dq_d = f0dv_d ? M_DQ : f0dq_q;
        f1dq_d = f1dv_d ? M_DQ : f1dq_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_q   <= 1'b0;
            bcnt_q <= '0;
            hdq_q  <= '0;
            f0dq_q <= '0;
            f1dq_q <= '0;
            hdv_q  <= 1'b0;
            f0dv_q <= 1'b0;
            f1dv_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            bcnt_q <= bcnt_d;
            hdq_q  <= hdq_d;
            f0dq_q <= f0dq_d;
            f1dq_q <= f1dq_d;
            hdv_q  <= hdv_d;
            f0dv_q <= f0dv_d;
            f1dv_q <= f1dv_d;
        end
    end

    assign H_DQ  = hdq_q;
    assign H_DV  = hdv_q;
    assign F0_DQ = f0dq_q;
    assign F0_DV = f0dv_q;
    assign F1_DQ = f1dq_q;
    assign F1_DV = f1dv_q;

endmodule
